// File: rtl/cache_stats_pkg.sv
// Shared types and constants for the cache statistics counters.
// Optional saturation is enabled by CACHE_STATS_SAT_EN.
package cache_stats_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int N_CNT     = 7;

  localparam logic [3:0] OP_CLEAR = 4'd8;
  localparam logic [3:0] OP_PRINT = 4'd9;

  typedef enum logic [2:0] {
    C_IRD   = 3'd0,
    C_IHIT  = 3'd1,
    C_IMISS = 3'd2,
    C_DRD   = 3'd3,
    C_DWR   = 3'd4,
    C_DHIT  = 3'd5,
    C_DMISS = 3'd6
  } cnt_idx_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] ins_reads;
    logic [CNT_W_DEF-1:0] ins_hit;
    logic [CNT_W_DEF-1:0] ins_miss;
    logic [CNT_W_DEF-1:0] data_reads;
    logic [CNT_W_DEF-1:0] data_writes;
    logic [CNT_W_DEF-1:0] data_hit;
    logic [CNT_W_DEF-1:0] data_miss;
  } cnt_bundle_t;

  typedef struct packed {
    logic i_rd;
    logic i_hit;
    logic i_miss;
    logic d_rd;
    logic d_wr;
    logic d_hit;
    logic d_miss;
    logic clear;
    logic print;
  } evt_t;

  // Outcome strobes only count when paired with a matching access.
  function automatic logic [N_CNT-1:0] evt_incs(evt_t e);
    logic [N_CNT-1:0] v;
    logic d_acc;
    v        = '0;
    d_acc    = e.d_rd | e.d_wr;
    v[C_IRD]   = e.i_rd;
    v[C_IHIT]  = e.i_rd & e.i_hit & ~e.i_miss;
    v[C_IMISS] = e.i_rd & e.i_miss & ~e.i_hit;
    v[C_DRD]   = e.d_rd;
    v[C_DWR]   = e.d_wr;
    v[C_DHIT]  = d_acc & e.d_hit & ~e.d_miss;
    v[C_DMISS] = d_acc & e.d_miss & ~e.d_hit;
    return v;
  endfunction

  function automatic logic evt_viol(evt_t e);
    logic d_acc;
    d_acc = e.d_rd | e.d_wr;
    return (e.i_hit & e.i_miss)
         | (e.d_rd & e.d_wr)
         | (e.d_hit & e.d_miss)
         | ((e.d_hit | e.d_miss) & ~d_acc);
  endfunction

endpackage

// File: rtl/cache_stats_counters_counter.sv
// Single statistics counter with clear-and-load and optional saturation.
// Saturation and the overflow flag exist only with CACHE_STATS_SAT_EN.
module stats_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] inc_w;

  assign inc_w = {{(W-1){1'b0}}, inc_i};

`ifdef CACHE_STATS_SAT_EN
  logic ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = inc_w;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + inc_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  always_comb begin
    cnt_d = cnt_q + inc_w;
    if (clr_i) cnt_d = inc_w;
  end

  assign ovf_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_stats_counters.sv
// L1 I/D cache statistics producer: event pipeline, validity, print/clear.
// Define CACHE_STATS_SAT_EN for saturating counters with sticky ovf.
module cache_stats_counters
  import cache_stats_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PIPE_EVT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rd,
  input  logic             i_hit,
  input  logic             i_miss,
  input  logic             d_rd,
  input  logic             d_wr,
  input  logic             d_hit,
  input  logic             d_miss,
  input  logic             clear_req,
  input  logic             print_req,
  output logic [CNT_W-1:0] ins_reads,
  output logic [CNT_W-1:0] ins_hit,
  output logic [CNT_W-1:0] ins_miss,
  output logic [CNT_W-1:0] data_reads,
  output logic [CNT_W-1:0] data_writes,
  output logic [CNT_W-1:0] data_hit,
  output logic [CNT_W-1:0] data_miss,
  output logic             print,
  output logic             proto_err,
  output logic             ovf
);

  evt_t             ev_in, ev_s1;
  logic [N_CNT-1:0] inc;
  logic [N_CNT-1:0] ovf_v;
  logic [CNT_W-1:0] cnt [N_CNT];
  logic             viol;
  logic             print_q, clr_q, proto_q;
  logic             proto_d;

  assign ev_in = '{
    i_rd:   i_rd,
    i_hit:  i_hit,
    i_miss: i_miss,
    d_rd:   d_rd,
    d_wr:   d_wr,
    d_hit:  d_hit,
    d_miss: d_miss,
    clear:  clear_req,
    print:  print_req
  };

  if (PIPE_EVT != 0) begin : g_pipe
    evt_t ev_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ev_q <= '0;
      else        ev_q <= ev_in;
    end
    assign ev_s1 = ev_q;
  end else begin : g_nopipe
    assign ev_s1 = ev_in;
  end

  assign inc  = evt_incs(ev_s1);
  assign viol = evt_viol(ev_s1);

  // Print and clear trail the counted events by one register so the
  // strobe lands on the first cycle that includes them.
  always_comb begin
    proto_d = proto_q | viol;
    if (clr_q) proto_d = viol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      print_q <= 1'b0;
      clr_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      print_q <= ev_s1.print;
      clr_q   <= ev_s1.clear;
      proto_q <= proto_d;
    end
  end

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    stats_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (inc[g]),
      .clr_i (clr_q),
      .cnt_o (cnt[g]),
      .ovf_o (ovf_v[g])
    );
  end

  assign ins_reads   = cnt[C_IRD];
  assign ins_hit     = cnt[C_IHIT];
  assign ins_miss    = cnt[C_IMISS];
  assign data_reads  = cnt[C_DRD];
  assign data_writes = cnt[C_DWR];
  assign data_hit    = cnt[C_DHIT];
  assign data_miss   = cnt[C_DMISS];
  assign print       = print_q;
  assign proto_err   = proto_q;
  assign ovf         = |ovf_v;

endmodule

// File: tb/tb_cache_stats_counters.sv
// Directed bench: 32-bit piped instance plus 4-bit unpiped instance.
// Expected saturation results follow CACHE_STATS_SAT_EN.
module tb_cache_stats_counters;

  logic clk = 1'b0;
  logic rst_n;
  logic i_rd, i_hit, i_miss, d_rd, d_wr, d_hit, d_miss;
  logic clear_req, print_req;

  logic [31:0] ins_reads, ins_hit, ins_miss;
  logic [31:0] data_reads, data_writes, data_hit, data_miss;
  logic        print, proto_err, ovf;

  logic [3:0] s_ins_reads, s_ins_hit, s_ins_miss;
  logic [3:0] s_data_reads, s_data_writes, s_data_hit, s_data_miss;
  logic       s_print, s_proto_err, s_ovf;

  int total  = 0;
  int passed = 0;
  logic seen_print;

  always #5 clk = ~clk;

  cache_stats_counters #(.CNT_W(32), .PIPE_EVT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd(i_rd), .i_hit(i_hit), .i_miss(i_miss),
    .d_rd(d_rd), .d_wr(d_wr), .d_hit(d_hit), .d_miss(d_miss),
    .clear_req(clear_req), .print_req(print_req),
    .ins_reads(ins_reads), .ins_hit(ins_hit), .ins_miss(ins_miss),
    .data_reads(data_reads), .data_writes(data_writes),
    .data_hit(data_hit), .data_miss(data_miss),
    .print(print), .proto_err(proto_err), .ovf(ovf)
  );

  cache_stats_counters #(.CNT_W(4), .PIPE_EVT(0)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_rd(i_rd), .i_hit(i_hit), .i_miss(i_miss),
    .d_rd(d_rd), .d_wr(d_wr), .d_hit(d_hit), .d_miss(d_miss),
    .clear_req(clear_req), .print_req(print_req),
    .ins_reads(s_ins_reads), .ins_hit(s_ins_hit), .ins_miss(s_ins_miss),
    .data_reads(s_data_reads), .data_writes(s_data_writes),
    .data_hit(s_data_hit), .data_miss(s_data_miss),
    .print(s_print), .proto_err(s_proto_err), .ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (print === 1'b1) seen_print = 1'b1;
    end
  endtask

  task automatic idle();
    {i_rd, i_hit, i_miss, d_rd, d_wr, d_hit, d_miss} = '0;
    clear_req = 1'b0;
    print_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    seen_print = 1'b0;
    #12;
    chk("rst_ins_reads", ins_reads, 0);
    chk("rst_data_reads", data_reads, 0);
    chk("rst_print", {31'd0, print}, 0);
    chk("rst_proto", {31'd0, proto_err}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // instruction reads then print
    for (int k = 0; k < 5; k++) begin
      i_rd = 1; i_hit = 1; i_miss = 0; cyc();
    end
    for (int k = 0; k < 3; k++) begin
      i_rd = 1; i_hit = 0; i_miss = 1; cyc();
    end
    idle(); print_req = 1; cyc();
    idle();
    chk("p1_print_early", {31'd0, print}, 0);
    chk("p1_s_print_lat1", {31'd0, s_print}, 1);
    chk("p1_s_ins_reads", {28'd0, s_ins_reads}, 8);
    cyc();
    chk("p1_print", {31'd0, print}, 1);
    chk("p1_ins_reads", ins_reads, 8);
    chk("p1_ins_hit", ins_hit, 5);
    chk("p1_ins_miss", ins_miss, 3);
    chk("p1_data_reads", data_reads, 0);
    chk("p1_data_miss", data_miss, 0);
    cyc();
    chk("p1_print_off", {31'd0, print}, 0);

    // data accesses, print with last write
    for (int k = 0; k < 4; k++) begin
      idle(); d_rd = 1; d_hit = 1; cyc();
    end
    idle(); d_wr = 1; d_miss = 1; cyc();
    idle(); d_wr = 1; d_miss = 1; print_req = 1; cyc();
    idle(); cyc();
    chk("p2_print", {31'd0, print}, 1);
    chk("p2_data_reads", data_reads, 4);
    chk("p2_data_writes", data_writes, 2);
    chk("p2_data_hit", data_hit, 4);
    chk("p2_data_miss", data_miss, 2);
    chk("p2_proto", {31'd0, proto_err}, 0);

    // plain clear
    clear_req = 1; cyc();
    idle(); cyc(2);
    chk("clr_ins_reads", ins_reads, 0);
    chk("clr_data_hit", data_hit, 0);

    // print+clear with an event in flight
    for (int k = 0; k < 10; k++) begin
      idle(); d_rd = 1; cyc();
    end
    idle(); print_req = 1; clear_req = 1; cyc();
    idle(); d_rd = 1; cyc();
    idle();
    chk("pc_print", {31'd0, print}, 1);
    chk("pc_data_reads", data_reads, 10);
    cyc();
    chk("pc_post_reads", data_reads, 1);
    chk("pc_post_writes", data_writes, 0);
    chk("pc_post_print", {31'd0, print}, 0);

    // instruction hit+miss violation
    i_rd = 1; i_hit = 1; i_miss = 1; cyc();
    idle(); cyc();
    chk("pe_ins_reads", ins_reads, 1);
    chk("pe_ins_hit", ins_hit, 0);
    chk("pe_ins_miss", ins_miss, 0);
    chk("pe_proto", {31'd0, proto_err}, 1);
    clear_req = 1; cyc();
    idle(); cyc();
    chk("pe_proto_hold", {31'd0, proto_err}, 1);
    cyc();
    chk("pe_proto_clr", {31'd0, proto_err}, 0);

    // data outcome without access
    d_hit = 1; cyc();
    idle(); cyc();
    chk("pd_proto", {31'd0, proto_err}, 1);
    chk("pd_data_hit", data_hit, 0);

    // overflow on the 4-bit instance
    rst_n = 0; #1;
    chk("ov_rst_proto", {31'd0, proto_err}, 0);
    cyc();
    rst_n = 1; cyc();
    for (int k = 0; k < 17; k++) begin
      idle(); d_rd = 1; cyc();
    end
    idle(); cyc(2);
    chk("ov_wide_reads", data_reads, 17);
    chk("ov_wide_ovf", {31'd0, ovf}, 0);
`ifdef CACHE_STATS_SAT_EN
    chk("ov_s_reads", {28'd0, s_data_reads}, 15);
    chk("ov_s_ovf", {31'd0, s_ovf}, 1);
`else
    chk("ov_s_reads", {28'd0, s_data_reads}, 1);
    chk("ov_s_ovf", {31'd0, s_ovf}, 0);
`endif

    // reset one cycle after print_req
    d_rd = 1; print_req = 1; cyc();
    idle();
    seen_print = 1'b0;
    rst_n = 0; #1;
    chk("rm_async_reads", data_reads, 0);
    cyc();
    rst_n = 1;
    cyc(4);
    chk("rm_no_print", {31'd0, seen_print}, 0);
    chk("rm_data_reads", data_reads, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
